// File: rtl/spi_master.sv
// SPI master for a CPOL=0 / CPHA=0 link with an active-high chip select.
// Full duplex, MSB first; a lead and trail gap of CLK_DIV cycles frames each word.
module spi_master #(
  parameter int NB_BITS = 32,
  parameter int CLK_DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_data,
  input  logic               i_MISO,
  output logic               o_MOSI,
  output logic               o_SCLK,
  output logic               o_cs,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BIT_W = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t             state_q;
  logic [NB_BITS-1:0] tx_q;
  logic [NB_BITS-1:0] rx_q;
  logic [NB_BITS-1:0] data_q;
  logic [BIT_W-1:0]   bit_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic               div_end;
  logic               mosi_q;
  logic               sclk_q;
  logic               cs_q;
  logic               busy_q;
  logic               done_q;

  assign div_end = (div_q == DIV_LAST);
  assign div_d   = div_end ? '0 : div_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cs_q   <= 1'b0;
          sclk_q <= 1'b0;
          busy_q <= 1'b0;
          if (i_start) begin
            tx_q    <= i_data;
            mosi_q  <= i_data[NB_BITS-1];
            cs_q    <= 1'b1;
            busy_q  <= 1'b1;
            bit_q   <= '0;
            div_q   <= '0;
            state_q <= LEAD;
          end
        end
        LEAD: begin
          div_q <= div_d;
          if (div_end) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[NB_BITS-2:0], i_MISO};
            state_q <= XFER;
          end
        end
        XFER: begin
          div_q <= div_d;
          if (div_end) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[NB_BITS-2:0], i_MISO};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= TRAIL;
              end else begin
                // Rotate rather than zero-fill; the wrapped bit is never driven out.
                tx_q   <= {tx_q[NB_BITS-2:0], tx_q[NB_BITS-1]};
                mosi_q <= tx_q[NB_BITS-2];
                bit_q  <= bit_q + 1'b1;
              end
            end
          end
        end
        TRAIL: begin
          div_q <= div_d;
          if (div_end) begin
            // busy stays high through this completion cycle and drops in IDLE.
            cs_q    <= 1'b0;
            data_q  <= rx_q;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_MOSI = mosi_q;
  assign o_SCLK = sclk_q;
  assign o_cs   = cs_q;
  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: 32-bit/div-4 instance for loopback, slave and reset
// scenarios, plus an 8-bit/div-2 instance for back-to-back transfers.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  // 32-bit instance
  logic        start_a;
  logic [31:0] data_a;
  logic        miso_a, mosi_a, sclk_a, cs_a, busy_a, done_a;
  logic [31:0] q_a;
  logic [1:0]  mode;

  // on-chip slave model, edge-detected on the system clock
  logic [31:0] slv_load, slv_tx, slv_rx;
  logic        s_sclk_q, s_cs_q;

  assign miso_a = (mode == 2'd0) ? mosi_a : (mode == 2'd1) ? slv_tx[31] : 1'b1;

  spi_master #(.NB_BITS(32), .CLK_DIV(4)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_data(data_a), .i_MISO(miso_a),
    .o_MOSI(mosi_a), .o_SCLK(sclk_a), .o_cs(cs_a), .o_data(q_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  // 8-bit instance, always loopback
  logic       start_b;
  logic [7:0] data_b;
  logic       mosi_b, sclk_b, cs_b, busy_b, done_b;
  logic [7:0] q_b;

  spi_master #(.NB_BITS(8), .CLK_DIV(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_data(data_b), .i_MISO(mosi_b),
    .o_MOSI(mosi_b), .o_SCLK(sclk_b), .o_cs(cs_b), .o_data(q_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  always @(posedge clk) begin
    s_sclk_q <= sclk_a;
    s_cs_q   <= cs_a;
    if (cs_a && !s_cs_q) slv_tx <= slv_load;
    else if (cs_a && s_sclk_q && !sclk_a) slv_tx <= {slv_tx[30:0], 1'b0};
    if (cs_a && !s_sclk_q && sclk_a) slv_rx <= {slv_rx[30:0], mosi_a};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // per-transfer observations of instance A
  int          cs_first, done_cnt, done_cyc, rise_cnt, rise_bad, mosi_bad, sclk_bad;
  logic [31:0] done_data;
  logic        first_mosi, busy_done, busy_after, p_sclk, p_mosi, p_cs;

  task automatic run_a(input logic [1:0] md, input logic [31:0] data,
                       input logic [31:0] data_after, input int repulse, input int rst_at);
    mode = md;
    data_a = data;
    cs_first = -1; done_cnt = 0; done_cyc = -10; rise_cnt = 0; rise_bad = 0;
    mosi_bad = 0; sclk_bad = 0; done_data = '0; first_mosi = 1'b0;
    busy_done = 1'b0; busy_after = 1'b1;
    @(negedge clk);
    p_sclk = sclk_a; p_mosi = mosi_a; p_cs = cs_a;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 275; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cs_a && cs_first < 0) cs_first = cyc;
      if (sclk_a && !p_sclk) begin
        if (rise_cnt == 0) first_mosi = mosi_a;
        if (cyc != 5 + 8 * rise_cnt) rise_bad++;
        rise_cnt++;
      end
      if (mosi_a !== p_mosi && !(p_sclk && !sclk_a) && !(cs_a && !p_cs)) mosi_bad++;
      if (sclk_a && !cs_a) sclk_bad++;
      if (done_a) begin
        done_cnt++;
        done_cyc  = cyc;
        done_data = q_a;
        busy_done = busy_a;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy_a;
      p_sclk = sclk_a; p_mosi = mosi_a; p_cs = cs_a;
      if (cyc == 1) start_a = 1'b0;
      if (cyc == 2) data_a = data_after;
      if (cyc == repulse) start_a = 1'b1;
      if (cyc == repulse + 1) start_a = 1'b0;
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_async_ctl", {28'd0, cs_a, sclk_a, busy_a, done_a}, 32'd0);
        check("rst_async_data", q_a, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    $display("xfer tx=%h mode=%0d dones=%0d at cycle %0d rx=%h", data, md, done_cnt, done_cyc, done_data);
  endtask

  task automatic check_full(input string tag, input logic [31:0] exp_q, input logic exp_mosi);
    check({tag, "_cs_t0"}, cs_first, 1);
    check({tag, "_done_n"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, 261);
    check({tag, "_data"}, done_data, exp_q);
    check({tag, "_busy_done"}, 32'(busy_done), 32'd1);
    check({tag, "_busy_after"}, 32'(busy_after), 32'd0);
    check({tag, "_rises"}, rise_cnt, 32);
    check({tag, "_rise_cyc"}, rise_bad, 0);
    check({tag, "_mosi_stable"}, mosi_bad, 0);
    check({tag, "_sclk_no_cs"}, sclk_bad, 0);
    check({tag, "_first_mosi"}, 32'(first_mosi), 32'(exp_mosi));
  endtask

  int   dn_b, low_run;
  logic p_cs_b;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    mode = 2'd0; slv_load = '0;
    repeat (3) @(negedge clk);
    check("reset_a_ctl", {27'd0, cs_a, sclk_a, mosi_a, busy_a, done_a}, 32'd0);
    check("reset_a_data", q_a, 32'd0);
    check("reset_b", {19'd0, cs_b, sclk_b, mosi_b, busy_b, done_b, q_b}, 32'd0);
    rst = 1'b0;

    // loopback; i_data changed after acceptance must not matter
    run_a(2'd0, 32'hA5A5_0F0F, 32'h5A5A_F0F0, -1, -1);
    check_full("loop", 32'hA5A5_0F0F, 1'b1);

    // against the slave model
    slv_load = 32'h1234_5678;
    run_a(2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, -1, -1);
    check_full("slave", 32'h1234_5678, 1'b1);
    check("slave_rx", slv_rx, 32'hDEAD_BEEF);

    // MISO stuck high, re-pulse of i_start while busy
    run_a(2'd2, 32'h0000_0000, 32'h0000_0000, 100, -1);
    check_full("ones", 32'hFFFF_FFFF, 1'b0);

    // reset mid-transfer, then a clean transfer
    run_a(2'd0, 32'h0000_FFFF, 32'h0000_FFFF, -1, 120);
    check("rst_no_done", done_cnt, 0);
    run_a(2'd0, 32'h1357_9BDF, 32'h1357_9BDF, -1, -1);
    check_full("after_rst", 32'h1357_9BDF, 1'b0);

    // back-to-back on the 8-bit instance with i_start held high
    data_b = 8'h3C;
    dn_b = 0; low_run = 0;
    @(negedge clk);
    p_cs_b = cs_b;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_b) begin
        dn_b++;
        check("b_done_cyc", cyc, 35 * dn_b);
        check("b_data", 32'(q_b), 32'h3C);
        $display("xfer b #%0d done at cycle %0d rx=%h", dn_b, cyc, q_b);
      end
      if (cs_b && !p_cs_b) begin
        if (dn_b > 0) check("b_cs_gap", 32'(low_run >= 1), 32'd1);
        low_run = 0;
      end
      if (!cs_b) low_run++;
      p_cs_b = cs_b;
    end
    start_b = 1'b0;
    check("b_done_count", dn_b, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
